deflate_word_packer: RTL and testbench

- Sits directly downstream of the 64-bit bit-packing barrel shifter in the Deflate output path.
- Collects the 32-bit completed words the shifter emits, packs OUT_WORDS of them into one wide beat, and hands that beat to the memory writer over a valid/ready handshake.
- On end of stream it appends the shifter's residual bits (0..63), zero-pads the beat, marks it last, and reports the total compressed byte count.

---
 rtl/deflate_word_packer_if.sv | 31 +++
 rtl/deflate_word_packer.sv | 186 ++++++++++++++++++
 tb/tb_deflate_word_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deflate_word_packer_if.sv
// Word-packer bus bundle: the shifter-side word/flush inputs plus the beat output and stream status.
// Pure wiring; it adds no latency.
// The slave modport is the packer itself, and the master modport is its environment.
interface deflate_word_packer_if #(
    parameter int OUT_WORDS = 16,
    parameter int CNT_W     = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_data;
    logic                   flush;
    logic [63:0]            tail_data;
    logic [5:0]             tail_len;
    logic                   out_valid;
    logic [32*OUT_WORDS-1:0] out_data;
    logic                   out_last;
    logic                   out_ready;
    logic [CNT_W-1:0]       total_bytes;
    logic                   done;
    logic                   overflow;

    modport slave (
        input  in_valid, in_data, flush, tail_data, tail_len, out_ready,
        output in_ready, out_valid, out_data, out_last, total_bytes, done, overflow
    );

    modport master (
        output in_valid, in_data, flush, tail_data, tail_len, out_ready,
        input  in_ready, out_valid, out_data, out_last, total_bytes, done, overflow
    );
endinterface

// File: rtl/deflate_word_packer.sv
// Packs 32-bit shifter words into OUT_WORDS-wide beats, then appends the flush tail and emits a zero-padded last beat.
// Latency: the beat completed by a word or tail word is registered and appears one cycle after that word.
// Backpressure: the output register holds until out_ready. Only the word that fills the last slot stalls; words offered while stalled are dropped and flagged.
module deflate_word_packer #(
    parameter int OUT_WORDS = 16,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    deflate_word_packer_if.slave bus
);
    localparam int IDX_W = $clog2(OUT_WORDS);
    localparam int OW    = 32 * OUT_WORDS;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(OUT_WORDS - 1);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_TAIL  = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]                  r_state;
    logic [IDX_W-1:0]            r_idx;
    logic [OUT_WORDS-1:0][31:0]  r_acc;
    logic [63:0]                 r_tail;
    logic [1:0]                  r_tw;
    logic                        r_last_prod;   // the out_last beat is already loaded or sent
    logic                        r_out_valid;
    logic [OW-1:0]               r_out_data;
    logic                        r_out_last;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            r_total;
    logic                        r_done;
    logic                        r_ovf;

    logic                        w_out_free;
    logic                        w_slot_ok;
    logic                        w_in_ready;
    logic                        w_in_acc;
    logic                        w_flush_acc;
    logic                        w_wr_en;
    logic [31:0]                 w_wr_dat;
    logic                        w_wr_beat;
    logic                        w_tail_final;
    logic                        w_emit_load;
    logic                        w_last_hs;
    logic [63:0]                 w_tail_mask;
    logic [1:0]                  w_tail_words;
    logic [CNT_W-1:0]            w_tail_bytes;
    logic [CNT_W-1:0]            w_cnt_add;
    logic [OUT_WORDS-1:0][31:0]  w_full;
    logic [OUT_WORDS-1:0][31:0]  w_masked;

    // Stall only when a write would complete a beat while the output register is still occupied.
    assign w_out_free   = !r_out_valid || bus.out_ready;
    assign w_slot_ok    = (r_idx != LAST_SLOT) || w_out_free;
    assign w_in_ready   = (r_state == S_ACCUM) && w_slot_ok;
    assign w_in_acc     = bus.in_valid && w_in_ready;
    assign w_flush_acc  = bus.flush && (r_state == S_ACCUM);
    assign w_wr_en      = w_in_acc || ((r_state == S_TAIL) && w_slot_ok);
    assign w_wr_dat     = (r_state == S_TAIL) ? r_tail[31:0] : bus.in_data;
    assign w_wr_beat    = w_wr_en && (r_idx == LAST_SLOT);
    assign w_tail_final = (r_state == S_TAIL) && w_wr_en && (r_tw == 2'd1);
    assign w_emit_load  = (r_state == S_EMIT) && !r_last_prod && w_out_free;
    assign w_last_hs    = (r_state == S_EMIT) && r_out_valid && bus.out_ready && r_out_last;

    assign w_tail_mask  = (64'd1 << bus.tail_len) - 64'd1;
    assign w_tail_words = 2'(({1'b0, bus.tail_len} + 7'd31) >> 5);
    assign w_tail_bytes = CNT_W'(({1'b0, bus.tail_len} + 7'd7) >> 3);
    assign w_cnt_add    = (w_in_acc ? CNT_W'(4) : '0) + (w_flush_acc ? w_tail_bytes : '0);

    // Beat images: the accumulator including this cycle's write, and the partial accumulator with unused slots zeroed.
    always_comb begin
        w_full         = r_acc;
        w_full[r_idx]  = w_wr_dat;
        w_masked       = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (IDX_W'(k) < r_idx) begin
                w_masked[k] = r_acc[k];
            end
        end
    end

    // Stream control: slot index, tail shift register and ACCUM/TAIL/EMIT sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_ACCUM;
            r_idx       <= '0;
            r_tail      <= '0;
            r_tw        <= '0;
            r_last_prod <= 1'b0;
        end else begin
            if (w_last_hs) begin
                r_idx <= '0;
            end else if (w_wr_en) begin
                r_idx <= (r_idx == LAST_SLOT) ? '0 : r_idx + IDX_W'(1);
            end

            case (r_state)
                S_ACCUM: begin
                    if (w_flush_acc) begin
                        r_tail      <= bus.tail_data & w_tail_mask;
                        r_tw        <= w_tail_words;
                        r_last_prod <= 1'b0;
                        r_state     <= (w_tail_words == 2'd0) ? S_EMIT : S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (w_wr_en) begin
                        r_tail <= r_tail >> 32;
                        r_tw   <= r_tw - 2'd1;
                        if (r_tw == 2'd1) begin
                            r_state     <= S_EMIT;
                            r_last_prod <= (r_idx == LAST_SLOT);
                        end
                    end
                end
                S_EMIT: begin
                    if (w_emit_load) begin
                        r_last_prod <= 1'b1;
                    end
                    if (w_last_hs) begin
                        r_last_prod <= 1'b0;
                        r_state     <= S_ACCUM;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    // Accumulator slots are written by either shifter words or tail words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_wr_en) begin
            r_acc[r_idx] <= w_wr_dat;
        end
    end

    // Output register: load a full or final beat, or drop valid once the beat has been taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_wr_beat) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_full;
            r_out_last  <= w_tail_final;
        end else if (w_emit_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_masked;
            r_out_last  <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Byte accounting, completion pulse and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_total <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (w_last_hs) begin
                r_total <= r_cnt;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + w_cnt_add;
            end
            if (bus.in_valid && !w_in_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_last    = r_out_last;
    assign bus.total_bytes = r_total;
    assign bus.done        = r_done;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_deflate_word_packer.sv
// Scoreboard bench for deflate_word_packer: directed streams push their expected beats and byte totals.
// A negedge monitor pops these expectations on every handshake and done pulse.
// Covers the full-beat, tail-split, tail-fills-beat, empty-stream, overflow and async-reset cases.
module tb_deflate_word_packer;
    localparam int OW = 16;

    typedef struct {
        logic [32*OW-1:0] data;
        logic             last;
    } beat_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    beat_t       exp_q[$];
    logic [31:0] tot_q[$];

    deflate_word_packer_if #(.OUT_WORDS(OW), .CNT_W(32)) bus ();

    deflate_word_packer #(.OUT_WORDS(OW), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32*OW-1:0] act, input logic [32*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [32*OW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send_word(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for word %h", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [63:0] td, input logic [5:0] tl);
        bus.flush     = 1'b1;
        bus.tail_data = td;
        bus.tail_len  = tl;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0, expected a pulse");
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every transferred beat and every completion against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        logic [31:0] t;
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h last=%0b, expected none", bus.out_data, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.out_data, e.data);
                    chk("beat_last", {511'd0, bus.out_last}, {511'd0, e.last});
                end
            end
            if (bus.done) begin
                if (tot_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got total=%0d, expected no done", bus.total_bytes);
                end else begin
                    t = tot_q.pop_front();
                    chk("total_bytes", {480'd0, bus.total_bytes}, {480'd0, t});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32*OW-1:0] b;
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.tail_data = '0;
        bus.tail_len  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {511'd0, bus.out_valid}, '0);
        chk("rst_out_last", {511'd0, bus.out_last}, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_total", {480'd0, bus.total_bytes}, '0);
        chk("rst_done", {511'd0, bus.done}, '0);
        chk("rst_overflow", {511'd0, bus.overflow}, '0);
        chk("rst_in_ready", {511'd0, bus.in_ready}, {511'd0, 1'b1});
        @(posedge clk);
        #1;

        // One full beat of words 1..16, then an empty tail gives an all-zero last beat.
        b = '0;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'(k + 1);
        push_beat(b, 1'b0);
        push_beat('0, 1'b1);
        tot_q.push_back(32'd64);
        for (int k = 0; k < 16; k++) send_word(32'(k + 1));
        do_flush(64'd0, 6'd0);
        wait_done();

        // Three words plus a 40-bit tail split across two slots.
        b = '0;
        b[31:0]    = 32'hA0A0_0001;
        b[63:32]   = 32'hB0B0_0002;
        b[95:64]   = 32'hC0C0_0003;
        b[127:96]  = 32'hFFFF_FFFF;
        b[159:128] = 32'h0000_00FF;
        push_beat(b, 1'b1);
        tot_q.push_back(32'd17);
        send_word(32'hA0A0_0001);
        send_word(32'hB0B0_0002);
        send_word(32'hC0C0_0003);
        do_flush(64'hFFFF_FFFF_FFFF_FFFF, 6'd40);
        wait_done();

        // Fourteen words plus a 63-bit tail that exactly fills the beat.
        b = '0;
        for (int k = 0; k < 14; k++) b[32*k +: 32] = 32'h5000 + 32'(k);
        b[479:448] = 32'h89AB_CDEF;
        b[511:480] = 32'h0123_4567;
        push_beat(b, 1'b1);
        tot_q.push_back(32'd64);
        for (int k = 0; k < 14; k++) send_word(32'h5000 + 32'(k));
        do_flush(64'h8123_4567_89AB_CDEF, 6'd63);
        wait_done();

        // Empty stream.
        push_beat('0, 1'b1);
        tot_q.push_back(32'd0);
        do_flush(64'hFFFF_FFFF_FFFF_FFFF, 6'd0);
        wait_done();
        chk("ovf_clear_before", {511'd0, bus.overflow}, '0);

        // Stalled output: last slot blocks, an extra word is dropped and flagged.
        bus.out_ready = 1'b0;
        b = '0;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'h100 + 32'(k);
        push_beat(b, 1'b0);
        b = '0;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'h200 + 32'(k);
        push_beat(b, 1'b0);
        push_beat('0, 1'b1);
        tot_q.push_back(32'd128);
        for (int k = 0; k < 16; k++) send_word(32'h100 + 32'(k));
        for (int k = 0; k < 15; k++) send_word(32'h200 + 32'(k));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_in_ready", {511'd0, bus.in_ready}, '0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("overflow_set", {511'd0, bus.overflow}, {511'd0, 1'b1});
        bus.out_ready = 1'b1;
        send_word(32'h20F);
        do_flush(64'd0, 6'd0);
        wait_done();
        chk("overflow_sticky", {511'd0, bus.overflow}, {511'd0, 1'b1});

        // Stall in TAIL, then an asynchronous reset clears everything.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 31; k++) send_word(32'h700 + 32'(k));
        do_flush(64'hFFFF_FFFF_FFFF_FFFF, 6'd40);
        repeat (3) @(posedge clk);
        #2;
        chk("tail_stall_valid", {511'd0, bus.out_valid}, {511'd0, 1'b1});
        chk("tail_stall_in_ready", {511'd0, bus.in_ready}, '0);
        reset = 1'b0;
        #1;
        chk("arst_out_valid", {511'd0, bus.out_valid}, '0);
        chk("arst_out_data", bus.out_data, '0);
        chk("arst_out_last", {511'd0, bus.out_last}, '0);
        chk("arst_total", {480'd0, bus.total_bytes}, '0);
        chk("arst_overflow", {511'd0, bus.overflow}, '0);
        chk("arst_done", {511'd0, bus.done}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        b = '0;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'h300 + 32'(k);
        push_beat(b, 1'b0);
        push_beat('0, 1'b1);
        tot_q.push_back(32'd64);
        for (int k = 0; k < 16; k++) send_word(32'h300 + 32'(k));
        do_flush(64'd0, 6'd0);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("beats_left", {480'd0, 32'(exp_q.size())}, '0);
        chk("totals_left", {480'd0, 32'(tot_q.size())}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
